// File: rtl/d_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package d_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT0  = 1'b0;
  localparam logic PORT1  = 1'b1;
  localparam int   WAIT_W = 4;

endpackage

// File: rtl/d_mem_arb_pick.sv
// Winner selection between the two requesters.
// D_MEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module d_mem_arb_pick
  import d_mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
`ifdef D_MEM_ARB_RR_EN
  input  logic       last_winner,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef D_MEM_ARB_RR_EN
    if (req0 && req1) begin
      if (last_winner == PORT1) gnt[PORT0] = 1'b1;
      else                      gnt[PORT1] = 1'b1;
    end else begin
      gnt[PORT0] = req0;
      gnt[PORT1] = req1;
    end
`else
    if (req0)      gnt[PORT0] = 1'b1;
    else if (req1) gnt[PORT1] = 1'b1;
`endif
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory; all memory-side
// outputs are registered. Optional round-robin via D_MEM_ARB_RR_EN.
module d_mem_arbiter
  import d_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              win;
  logic              we_q;
  logic [1:0]        pick;
  logic [1:0]        grant;
  logic              access_last;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef D_MEM_ARB_RR_EN
  logic last_winner;
`endif

  d_mem_arb_pick u_pick (
    .req0        (r0_req),
    .req1        (r1_req),
`ifdef D_MEM_ARB_RR_EN
    .last_winner (last_winner),
`endif
    .gnt         (pick)
  );

  assign access_last = (state == ACCESS) && (wait_cnt == WAIT_LAST);
  assign sel_we      = grant[PORT1] ? r1_we    : r0_we;
  assign sel_addr    = grant[PORT1] ? r1_addr  : r0_addr;
  assign sel_wdata   = grant[PORT1] ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant)     state_nxt = ACCESS;
      ACCESS:  if (access_last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is gated by rst_n so nothing is offered while registers are held.
  always_comb begin
    grant   = (state == IDLE && rst_n) ? pick : 2'b00;
    r0_gnt  = grant[PORT0];
    r1_gnt  = grant[PORT1];
    r0_done = (state == RESP) && (win == PORT0);
    r1_done = (state == RESP) && (win == PORT1);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      win         <= PORT0;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
`ifdef D_MEM_ARB_RR_EN
      last_winner <= PORT1;
`endif
    end else begin
      case (state)
        IDLE: if (|grant) begin
          win         <= grant[PORT1] ? PORT1 : PORT0;
          we_q        <= sel_we;
          mem_addr    <= sel_addr;
          mem_wdata   <= sel_wdata;
          mem_write   <= sel_we;
          mem_read    <= ~sel_we;
          wait_cnt    <= '0;
`ifdef D_MEM_ARB_RR_EN
          last_winner <= grant[PORT1] ? PORT1 : PORT0;
`endif
        end
        ACCESS: begin
          if (access_last) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            if (!we_q) begin
              if (win == PORT0) r0_rdata <= mem_rdata;
              else              r1_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
